// File: rtl/carry_resolve_pkg.sv
// Shared types and constants for the serial carry-resolution stage.
package carry_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CARRYBITS = 2;

  // Group counter is at least one bit wide, even for a single group.
  function automatic int grp_cnt_width(input int groups);
    if (groups > 1) begin
      return $clog2(groups);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/carry_resolve_group.sv
// Combinational ripple over one group of redundant symbols, producing
// canonical digits and a 2-bit carry into the next group.
module carry_resolve_group
  import carry_resolve_pkg::*;
#(
  parameter int SYMBOLSPERCYCLE = 8,
  parameter int LOGRADIX        = 16
) (
  input  logic [LOGRADIX:0]    sym_in   [SYMBOLSPERCYCLE],
  input  logic [CARRYBITS-1:0] carry_in,
  output logic [LOGRADIX-1:0]  sym_out  [SYMBOLSPERCYCLE],
  output logic [CARRYBITS-1:0] carry_out
);

  // Ripple the carry symbol by symbol; a 2-bit carry cannot overflow here.
  always_comb begin
    logic [LOGRADIX+1:0]  sum;
    logic [CARRYBITS-1:0] c;
    sum = '0;
    c   = carry_in;
    for (int s = 0; s < SYMBOLSPERCYCLE; s++) begin
      sum        = {1'b0, sym_in[s]} + {{LOGRADIX{1'b0}}, c};
      sym_out[s] = sum[LOGRADIX-1:0];
      c          = sum[LOGRADIX+1:LOGRADIX];
    end
    carry_out = c;
  end

endmodule

// File: rtl/carry_resolve_serial.sv
// Serial carry resolver: converts a redundant-form polynomial to canonical
// digits, one group of SYMBOLSPERCYCLE symbols per clock.
module carry_resolve_serial
  import carry_resolve_pkg::*;
#(
  parameter int NUMSYMBOLS      = 64,
  parameter int LOGRADIX        = 16,
  parameter int SYMBOLSPERCYCLE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGRADIX:0]    data_in   [NUMSYMBOLS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGRADIX-1:0]  data_out  [NUMSYMBOLS],
  output logic [CARRYBITS-1:0] carry_out
);

  localparam int G  = NUMSYMBOLS / SYMBOLSPERCYCLE;
  localparam int GW = grp_cnt_width(G);
  localparam int IW = (NUMSYMBOLS > 1) ? $clog2(NUMSYMBOLS) : 1;

  if (NUMSYMBOLS % SYMBOLSPERCYCLE != 0) begin : g_bad_cfg
    $error("NUMSYMBOLS must be a multiple of SYMBOLSPERCYCLE");
  end

  state_t               state_q, state_d;
  logic [GW-1:0]        grp_q, grp_d;
  logic [CARRYBITS-1:0] carry_q, carry_d;
  logic [LOGRADIX:0]    work_q [NUMSYMBOLS];
  logic [LOGRADIX:0]    work_d [NUMSYMBOLS];
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [IW-1:0]        sym_idx  [SYMBOLSPERCYCLE];
  logic [LOGRADIX:0]    grp_in   [SYMBOLSPERCYCLE];
  logic [LOGRADIX-1:0]  grp_out  [SYMBOLSPERCYCLE];
  logic [CARRYBITS-1:0] grp_cout;

  // Select the symbols of the active group out of the working register.
  always_comb begin
    for (int s = 0; s < SYMBOLSPERCYCLE; s++) begin
      sym_idx[s] = IW'(int'(grp_q) * SYMBOLSPERCYCLE + s);
      grp_in[s]  = work_q[sym_idx[s]];
    end
  end

  carry_resolve_group #(
    .SYMBOLSPERCYCLE (SYMBOLSPERCYCLE),
    .LOGRADIX        (LOGRADIX)
  ) u_group (
    .sym_in    (grp_in),
    .carry_in  (carry_q),
    .sym_out   (grp_out),
    .carry_out (grp_cout)
  );

  // Next-state, counter, carry and in-place write-back of the resolved group.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    carry_d     = carry_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d     = data_in;
          grp_d      = GW'(0);
          carry_d    = 2'd0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        for (int s = 0; s < SYMBOLSPERCYCLE; s++) begin
          work_d[sym_idx[s]] = {1'b0, grp_out[s]};
        end
        carry_d = grp_cout;
        if (grp_q == GW'(G - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grp_q       <= GW'(0);
      carry_q     <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int i = 0; i < NUMSYMBOLS; i++) begin
        work_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      work_q      <= work_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUMSYMBOLS; i++) begin
      data_out[i] = work_q[i][LOGRADIX-1:0];
    end
  end

  assign carry_out = carry_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_carry_resolve_serial.sv
// Self-checking bench for carry_resolve_serial: directed vector table,
// handshake corner sequences and a randomized run against a value model.
module tb_carry_resolve_serial;

  localparam int NS  = 4;
  localparam int LR  = 4;
  localparam int SPC = 2;
  localparam int G   = NS / SPC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [LR:0]   data_in  [NS];
  logic [LR-1:0] data_out [NS];
  logic [1:0]    carry_out;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [NS-1:0][LR:0]   sym;
    logic [NS-1:0][LR-1:0] exp_d;
    logic [1:0]            exp_c;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  carry_resolve_serial #(
    .NUMSYMBOLS      (NS),
    .LOGRADIX        (LR),
    .SYMBOLSPERCYCLE (SPC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  // Integer value of a redundant polynomial: sum of sym_i * 16^i.
  function automatic int model_value(input logic [NS-1:0][LR:0] s);
    int v;
    v = 0;
    for (int i = 0; i < NS; i++) v += int'(s[i]) << (LR * i);
    return v;
  endfunction

  function automatic int dut_value();
    int v;
    v = int'(carry_out) << (LR * NS);
    for (int i = 0; i < NS; i++) v += int'(data_out[i]) << (LR * i);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [NS-1:0][LR:0] s);
    for (int i = 0; i < NS; i++) data_in[i] = s[i];
  endtask

  task automatic check_out(input string name, input logic [NS-1:0][LR-1:0] ed,
                           input logic [1:0] ec);
    for (int i = 0; i < NS; i++)
      check($sformatf("%s_d%0d", name, i), int'(data_out[i]), int'(ed[i]));
    check({name, "_carry"}, int'(carry_out), int'(ec));
  endtask

  // One full transaction; hold > 0 stalls the consumer for that many cycles.
  task automatic apply_vec(input vec_t v, input string name, input int hold);
    int n;
    drive(v.sym);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check({name, "_accept"}, int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check({name, "_latency"}, n, G);
    check_out(name, v.exp_d, v.exp_c);
    for (int h = 0; h < hold; h++) begin
      step();
      check($sformatf("%s_hold%0d_valid", name, h), int'(out_valid), 1);
      check($sformatf("%s_hold%0d_ready", name, h), int'(in_ready), 0);
      check_out($sformatf("%s_hold%0d", name, h), v.exp_d, v.exp_c);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_consumed"}, int'(out_valid), 0);
    check({name, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int acc_t [2];
    int acc_n, out_n, t;
    int sent, got, cyc, expv;
    bit acc, cons;
    int q [$];
    logic [NS-1:0][LR:0] cur;

    vecs[0] = '{sym: {5'd31, 5'd31, 5'd31, 5'd31}, exp_d: {4'd1, 4'd1, 4'd0, 4'd15}, exp_c: 2'd2};
    vecs[1] = '{sym: {5'd0, 5'd0, 5'd15, 5'd16},   exp_d: {4'd0, 4'd1, 4'd0, 4'd0},  exp_c: 2'd0};
    vecs[2] = '{sym: {5'd4, 5'd3, 5'd2, 5'd1},     exp_d: {4'd4, 4'd3, 4'd2, 4'd1},  exp_c: 2'd0};
    vecs[3] = '{sym: {5'd0, 5'd0, 5'd0, 5'd31},    exp_d: {4'd0, 4'd0, 4'd1, 4'd15}, exp_c: 2'd0};
    vecs[4] = '{sym: {5'd5, 5'd5, 5'd5, 5'd5},     exp_d: {4'd5, 4'd5, 4'd5, 4'd5},  exp_c: 2'd0};

    drive('0);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_value", dut_value(), 0);

    // Directed table; the saturated vector also exercises backpressure.
    for (int i = 0; i < 5; i++)
      apply_vec(vecs[i], $sformatf("vec%0d", i), (i == 0) ? 5 : 0);

    // Back-to-back with in_valid held high across A and B.
    drive(vecs[2].sym);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc_n = 0; out_n = 0; t = 0;
    while (t < 40 && out_n < 2) begin
      if (in_valid && in_ready) begin acc_t[acc_n] = t; acc_n++; end
      if (out_valid && out_ready) begin
        check_out($sformatf("b2b_%0d", out_n), vecs[2+out_n].exp_d, vecs[2+out_n].exp_c);
        out_n++;
      end
      step();
      t++;
      if (acc_n == 1) drive(vecs[3].sym);
      if (acc_n == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_outputs", out_n, 2);
    check("b2b_accepts", acc_n, 2);
    check("b2b_interval", (acc_n == 2) ? acc_t[1] - acc_t[0] : -1, G + 2);

    // Reset during the first RUN cycle discards the partial result.
    drive(vecs[0].sym);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_value", dut_value(), 0);
    apply_vec(vecs[4], "after_rst", 0);

    // Randomized traffic against the integer-value model.
    sent = 0; got = 0; cyc = 0;
    cur = '0;
    while (got < 1000 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < NS; i++) cur[i] = 5'($urandom_range(0, 31));
        drive(cur);
        in_valid = 1'b1;
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        if (q.size() == 0) begin
          check("rand_unexpected_output", 1, 0);
        end else begin
          expv = q.pop_front();
          check("rand_value", dut_value(), expv);
          check("rand_carry", int'(carry_out), expv >> (LR * NS));
        end
        got++;
      end
      if (acc) begin
        q.push_back(model_value(cur));
        sent++;
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    check("rand_count", got, 1000);
    check("rand_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
